// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between two requesters.
// Each access runs IDLE -> ACCESS (-> RESP for reads) -> IDLE; the grant is
// decided in IDLE by round-robin or fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_gnt0,
    output logic              o_rvalid0,
    output logic [DATA_W-1:0] o_rdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt1,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_mem_we,
    output logic [ADDR_W-2:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned WADDR_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic                r_win;
    logic                w_win_nxt;
    logic                r_we;
    logic                w_we_nxt;
    logic                r_gnt0;
    logic                w_gnt0_nxt;
    logic                r_gnt1;
    logic                w_gnt1_nxt;
    logic                r_rvalid0;
    logic                w_rvalid0_nxt;
    logic                r_rvalid1;
    logic                w_rvalid1_nxt;
    logic                r_mem_we;
    logic                w_mem_we_nxt;
    logic [WADDR_W-1:0]  r_mem_addr;
    logic [WADDR_W-1:0]  w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                w_pick1;
    logic                w_unused_addr_lsb;

    // Byte-address bit 0 has no meaning for word accesses.
    assign w_unused_addr_lsb = i_addr0[0] ^ i_addr1[0];

    // Arbitration: port 1 wins alone, or on a tie when rotation/priority says so.
    always_comb begin
        w_pick1 = 1'b0;
        if (i_req0 && i_req1) begin
            w_pick1 = FIXED_PRIO ? 1'b0 : ~r_last;
        end else begin
            w_pick1 = i_req1;
        end
    end

    // Next-state and next registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_win_nxt       = r_win;
        w_we_nxt        = r_we;
        w_gnt0_nxt      = 1'b0;
        w_gnt1_nxt      = 1'b0;
        w_rvalid0_nxt   = 1'b0;
        w_rvalid1_nxt   = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    w_state_nxt     = ACCESS;
                    w_win_nxt       = w_pick1;
                    w_last_nxt      = w_pick1;
                    w_we_nxt        = w_pick1 ? i_we1 : i_we0;
                    w_mem_we_nxt    = w_pick1 ? i_we1 : i_we0;
                    w_mem_addr_nxt  = w_pick1 ? i_addr1[ADDR_W-1:1] : i_addr0[ADDR_W-1:1];
                    w_mem_wdata_nxt = w_pick1 ? i_wdata1 : i_wdata0;
                    w_gnt0_nxt      = ~w_pick1;
                    w_gnt1_nxt      = w_pick1;
                end
            end
            ACCESS: begin
                if (r_we) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt   = RESP;
                    w_rvalid0_nxt = ~r_win;
                    w_rvalid1_nxt = r_win;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; read data is held per port after its strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_win       <= 1'b0;
            r_we        <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_win       <= w_win_nxt;
            r_we        <= w_we_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_rvalid0   <= w_rvalid0_nxt;
            r_rvalid1   <= w_rvalid1_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            if (r_rvalid0) begin
                r_rdata0 <= i_mem_rdata;
            end
            if (r_rvalid1) begin
                r_rdata1 <= i_mem_rdata;
            end
        end
    end

    // Memory read data arrives during the strobe cycle, so it bypasses the hold register then.
    assign o_rdata0    = r_rvalid0 ? i_mem_rdata : r_rdata0;
    assign o_rdata1    = r_rvalid1 ? i_mem_rdata : r_rdata1;
    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_rvalid0   = r_rvalid0;
    assign o_rvalid1   = r_rvalid1;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int unsigned DEPTH = 128;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        fp_req0, fp_req1, fp_we0, fp_we1;
    logic [7:0]  fp_addr0, fp_addr1;
    logic [15:0] fp_wdata0, fp_wdata1, fp_mem_rdata;
    logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_we;
    logic [15:0] fp_rdata0, fp_rdata1, fp_mem_wdata;
    logic [6:0]  fp_mem_addr;

    logic [15:0] mem     [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    logic        mem_init;

    int          n_cmp;
    int          n_err;
    logic        m_last;
    logic [15:0] exp_rd0, exp_rd1;

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(1'b0)) u_rr (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .FIXED_PRIO(1'b1)) u_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0(fp_req0), .i_we0(fp_we0), .i_addr0(fp_addr0), .i_wdata0(fp_wdata0),
        .o_gnt0(fp_gnt0), .o_rvalid0(fp_rvalid0), .o_rdata0(fp_rdata0),
        .i_req1(fp_req1), .i_we1(fp_we1), .i_addr1(fp_addr1), .i_wdata1(fp_wdata1),
        .o_gnt1(fp_gnt1), .o_rvalid1(fp_rvalid1), .o_rdata1(fp_rdata1),
        .o_mem_we(fp_mem_we), .o_mem_addr(fp_mem_addr), .o_mem_wdata(fp_mem_wdata),
        .i_mem_rdata(fp_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_word(input int i);
        return 16'hA500 ^ 16'(i * 257);
    endfunction

    // Synchronous single-port memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) tick();
        rst = 1'b0; mem_init = 1'b0;
        m_last = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_we} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_strobes: got %b expected 00000", {gnt0, gnt1, rvalid0, rvalid1, mem_we});
            end
            n_cmp++;
            if ({mem_addr, mem_wdata} !== 23'h0) begin
                n_err++;
                $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata});
            end
            n_cmp++;
            if ({rdata0, rdata1} !== 32'h0) begin
                n_err++;
                $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1});
            end
            n_cmp++;
            if ({fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_we} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_fp_strobes: got %b expected 00000", {fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_we});
            end
        end
    endtask

    task automatic test_write();
        req0 = 1; we0 = 1; addr0 = 8'h0C; wdata0 = 16'h1234;
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_err++; $display("FAIL write_gnt: got %b expected 10", {gnt0, gnt1});
        end
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 7'h06, 16'h1234}) begin
            n_err++; $display("FAIL write_bus: got %h expected %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 7'h06, 16'h1234});
        end
        m_last = 1'b0;
        ref_mem[6] = 16'h1234;
        req0 = 0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, mem_we} !== 3'b0) begin
            n_err++; $display("FAIL write_end: got %b expected 000", {gnt0, gnt1, mem_we});
        end
        n_cmp++;
        if (mem[6] !== 16'h1234) begin
            n_err++; $display("FAIL write_mem: got %h expected 1234", mem[6]);
        end
    endtask

    task automatic test_read();
        req1 = 1; we1 = 0; addr1 = 8'h0C;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_we} !== 5'b01000) begin
            n_err++; $display("FAIL read_gnt: got %b expected 01000", {gnt0, gnt1, rvalid0, rvalid1, mem_we});
        end
        m_last = 1'b1;
        req1 = 0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0001) begin
            n_err++; $display("FAIL read_rvalid: got %b expected 0001", {gnt0, gnt1, rvalid0, rvalid1});
        end
        n_cmp++;
        if (rdata1 !== 16'h1234) begin
            n_err++; $display("FAIL read_data: got %h expected 1234", rdata1);
        end
        exp_rd1 = 16'h1234;
        tick();
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b00 || rdata1 !== exp_rd1) begin
            n_err++; $display("FAIL read_hold: got %b/%h expected 00/%h", {rvalid0, rvalid1}, rdata1, exp_rd1);
        end
    endtask

    task automatic test_round_robin();
        int          exp_port;
        logic [1:0]  eg;
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 16'hAAAA;
        req1 = 1; we1 = 1; addr1 = 8'h22; wdata1 = 16'h5555;
        exp_port = m_last ? 0 : 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                eg = (exp_port == 1) ? 2'b01 : 2'b10;
                m_last = (exp_port == 1);
                if (exp_port == 1) ref_mem[7'h11] = 16'h5555;
                else               ref_mem[7'h10] = 16'hAAAA;
                exp_port = 1 - exp_port;
            end else begin
                eg = 2'b00;
            end
            n_cmp++;
            if ({gnt0, gnt1} !== eg) begin
                n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, eg);
            end
        end
        req0 = 0; req1 = 0;
        tick();
    endtask

    task automatic test_fixed_prio();
        int cnt0, cnt1;
        bit got;
        fp_req0 = 1; fp_req1 = 1;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cnt0 += int'(fp_gnt0);
            cnt1 += int'(fp_gnt1);
        end
        n_cmp++;
        if (cnt0 !== 6 || cnt1 !== 0) begin
            n_err++; $display("FAIL fp_counts: got %0d/%0d expected 6/0", cnt0, cnt1);
        end
        fp_req0 = 0;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (fp_gnt1 === 1'b1) got = 1;
        end
        n_cmp++;
        if (got !== 1'b1) begin
            n_err++; $display("FAIL fp_port1_served: got %b expected 1", got);
        end
        fp_req1 = 0;
        tick(); tick();
    endtask

    task automatic test_reset_abort();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_err++; $display("FAIL abort_gnt: got %b expected 10", {gnt0, gnt1});
        end
        rst = 1; req0 = 0;
        tick();
        rst = 0;
        m_last = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_we} !== 5'b0 || {rdata0, rdata1} !== 32'h0) begin
            n_err++; $display("FAIL abort_reset: got %b/%h expected 00000/0", {gnt0, gnt1, rvalid0, rvalid1, mem_we}, {rdata0, rdata1});
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
            n_err++; $display("FAIL abort_no_rvalid: got %b expected 0000", {gnt0, gnt1, rvalid0, rvalid1});
        end
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 16'hBEEF;
        req1 = 1; we1 = 1; addr1 = 8'h32; wdata1 = 16'hCAFE;
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_err++; $display("FAIL abort_tie_winner: got %b expected 10", {gnt0, gnt1});
        end
        ref_mem[7'h18] = 16'hBEEF;
        m_last = 1'b0;
        req0 = 0;
        tick();
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b01) begin
            n_err++; $display("FAIL abort_port1_next: got %b expected 01", {gnt0, gnt1});
        end
        ref_mem[7'h19] = 16'hCAFE;
        m_last = 1'b1;
        req1 = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] eg, er;
        req0 = 1; we0 = 0; addr0 = 8'h01;
        req1 = 1; we1 = 0; addr1 = 8'h00;
        for (int n = 1; n <= 6; n++) begin
            tick();
            eg = (n == 1) ? 2'b10 : (n == 4) ? 2'b01 : 2'b00;
            er = (n == 2) ? 2'b10 : (n == 5) ? 2'b01 : 2'b00;
            if (n == 2) exp_rd0 = ref_mem[0];
            if (n == 5) exp_rd1 = ref_mem[0];
            n_cmp++;
            if ({gnt0, gnt1} !== eg || {rvalid0, rvalid1} !== er) begin
                n_err++; $display("FAIL b2b_strobes[%0d]: got %b/%b expected %b/%b", n, {gnt0, gnt1}, {rvalid0, rvalid1}, eg, er);
            end
            n_cmp++;
            if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1) begin
                n_err++; $display("FAIL b2b_rdata[%0d]: got %h/%h expected %h/%h", n, rdata0, rdata1, exp_rd0, exp_rd1);
            end
            if (n == 1) req0 = 0;
            if (n == 4) req1 = 0;
        end
        m_last = 1'b1;
    endtask

    task automatic test_random();
        int          gc, gp, rvc, rvp, free_at, w;
        logic        gwe;
        logic [6:0]  wa;
        logic [15:0] rvd;
        logic [1:0]  eg, er;
        gc = -1; gp = 0; rvc = -1; rvp = 0; free_at = 1; gwe = 0; rvd = '0;
        req0 = 0; req1 = 0;
        for (int cyc = 1; cyc <= 800; cyc++) begin
            @(posedge clk);
            if (cyc >= free_at && (req0 || req1)) begin
                if (req0 && req1) w = m_last ? 0 : 1;
                else              w = req1 ? 1 : 0;
                m_last = (w == 1);
                gc = cyc; gp = w;
                wa  = (w == 1) ? addr1[7:1] : addr0[7:1];
                gwe = (w == 1) ? we1 : we0;
                if (gwe) begin
                    ref_mem[wa] = (w == 1) ? wdata1 : wdata0;
                    free_at = cyc + 2;
                end else begin
                    rvc = cyc + 1; rvp = w; rvd = ref_mem[wa];
                    free_at = cyc + 3;
                end
            end
            #1;
            eg = {gc == cyc && gp == 0, gc == cyc && gp == 1};
            er = {rvc == cyc && rvp == 0, rvc == cyc && rvp == 1};
            if (er[1]) exp_rd0 = rvd;
            if (er[0]) exp_rd1 = rvd;
            n_cmp++;
            if ({gnt0, gnt1} !== eg) begin
                n_err++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", cyc, {gnt0, gnt1}, eg);
            end
            n_cmp++;
            if ({rvalid0, rvalid1} !== er) begin
                n_err++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", cyc, {rvalid0, rvalid1}, er);
            end
            n_cmp++;
            if (mem_we !== (gc == cyc && gwe)) begin
                n_err++; $display("FAIL rnd_mem_we[%0d]: got %b expected %b", cyc, mem_we, (gc == cyc && gwe));
            end
            n_cmp++;
            if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1) begin
                n_err++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", cyc, rdata0, rdata1, exp_rd0, exp_rd1);
            end
            // Requester 0 behaviour
            if (req0 && eg[1]) begin
                if ($urandom_range(1, 0) == 1) begin
                    we0 = 1'($urandom_range(1, 0)); addr0 = 8'($urandom); wdata0 = 16'($urandom);
                end else begin
                    req0 = 0;
                end
            end else if (req0) begin
                if ($urandom_range(9, 0) == 0) req0 = 0;
            end else if ($urandom_range(2, 0) == 0) begin
                req0 = 1; we0 = 1'($urandom_range(1, 0)); addr0 = 8'($urandom); wdata0 = 16'($urandom);
            end
            // Requester 1 behaviour
            if (req1 && eg[0]) begin
                if ($urandom_range(1, 0) == 1) begin
                    we1 = 1'($urandom_range(1, 0)); addr1 = 8'($urandom); wdata1 = 16'($urandom);
                end else begin
                    req1 = 0;
                end
            end else if (req1) begin
                if ($urandom_range(9, 0) == 0) req1 = 0;
            end else if ($urandom_range(2, 0) == 0) begin
                req1 = 1; we1 = 1'($urandom_range(1, 0)); addr1 = 8'($urandom); wdata1 = 16'($urandom);
            end
        end
        req0 = 0; req1 = 0;
        repeat (4) tick();
    endtask

    task automatic test_mem_contents();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (mem[i] !== ref_mem[i]) begin
                n_err++; $display("FAIL mem_word[%0d]: got %h expected %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1; mem_init = 1;
        fp_req0 = 0; fp_req1 = 0; fp_we0 = 1; fp_we1 = 1;
        fp_addr0 = 8'h02; fp_addr1 = 8'h04; fp_wdata0 = 16'h0F0F; fp_wdata1 = 16'hF0F0;
        fp_mem_rdata = 16'h0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_fixed_prio();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_mem_contents();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
